// File: rtl/clkgen_frac_ce.sv
// Multi-channel fractional clock-enable generator: DDS phase accumulators on refclk,
// a settle/lock sequencer, and a valid/ready port for run-time increment changes.
//
// state  | meaning
// SETTLE | settle counter running down; accumulators held at 0, ce/outclk quiet
// LOCKED | outputs valid; accumulators run; cfg transfers accepted
module clkgen_frac_ce #(
  parameter int NUM_CLOCKS = 2,
  parameter int ACC_WIDTH = 24,
  parameter logic [NUM_CLOCKS*ACC_WIDTH-1:0] INC_INIT = {24'h09756A, 24'h400000},
  parameter int LOCK_CYCLES = 16,
  parameter int SEL_W = 3
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [ACC_WIDTH-1:0]  cfg_inc,
  output logic [NUM_CLOCKS-1:0] ce,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W+1)'(NUM_CLOCKS);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic sel_in_range;
  logic cfg_hit;

  assign locked = (state == LOCKED);
  assign cfg_ready = locked;
  assign sel_in_range = ({1'b0, cfg_sel} < SEL_LIMIT);
  // Out-of-range selects complete the handshake but change nothing.
  assign cfg_hit = cfg_valid && cfg_ready && sel_in_range;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state <= SETTLE;
      cnt   <= CNT_LOAD;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      SETTLE: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = LOCKED;
      end
      LOCKED: begin
        if (cfg_hit) begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_LOAD;
        end
      end
      default: begin
        state_nxt = SETTLE;
        cnt_nxt   = CNT_LOAD;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] inc;
    logic                 ce_r;
    logic                 outclk_r;
    logic [ACC_WIDTH:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, inc};
    assign ce[i] = ce_r;
    assign outclk[i] = outclk_r;

    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        acc      <= '0;
        inc      <= INC_INIT[i*ACC_WIDTH +: ACC_WIDTH];
        ce_r     <= 1'b0;
        outclk_r <= 1'b0;
      end else begin
        if (cfg_hit && (cfg_sel == SEL_W'(i))) inc <= cfg_inc;
        // Any reprogramming restarts every channel so all phases realign after relock.
        if (cfg_hit) begin
          acc      <= '0;
          ce_r     <= 1'b0;
          outclk_r <= 1'b0;
        end else if (locked) begin
          acc      <= sum[ACC_WIDTH-1:0];
          ce_r     <= sum[ACC_WIDTH];
          outclk_r <= outclk_r ^ ce_r;
        end else begin
          acc      <= '0;
          ce_r     <= 1'b0;
          outclk_r <= outclk_r ^ ce_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_clkgen_frac_ce.sv
`timescale 1ns/1ps
// Bench for clkgen_frac_ce: a closed-form wrap-count model pushes per-edge expectations
// into a scoreboard queue that is popped and compared one step after each refclk edge.
module tb_clkgen_frac_ce;
  localparam int NCH = 2;
  localparam int AW = 24;
  localparam int LOCK = 16;
  localparam int SW = 3;
  localparam logic [NCH*AW-1:0] INIT = {24'h09756A, 24'h400000};

  logic refclk = 1'b0;
  logic rst = 1'b0;
  logic cfg_valid = 1'b0;
  logic [SW-1:0] cfg_sel = '0;
  logic [AW-1:0] cfg_inc = '0;
  logic cfg_ready;
  logic locked;
  logic [NCH-1:0] ce;
  logic [NCH-1:0] outclk;

  always #10 refclk = ~refclk;

  clkgen_frac_ce #(
    .NUM_CLOCKS(NCH),
    .ACC_WIDTH(AW),
    .INC_INIT(INIT),
    .LOCK_CYCLES(LOCK),
    .SEL_W(SW)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel),
    .cfg_inc(cfg_inc),
    .ce(ce),
    .outclk(outclk),
    .locked(locked)
  );

  typedef struct packed {
    logic [1:0] ce;
    logic [1:0] oc;
    logic       lk;
    logic       rd;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit m_locked;
  int m_settle;
  int m_k;
  logic [AW-1:0] m_inc [NCH];
  int obs_acc = 0;
  int mdl_acc = 0;

  // Number of accumulator wraps after k locked edges starting from zero phase.
  function automatic longint wraps(logic [AW-1:0] inc, int k);
    return (longint'(k) * longint'(inc)) >> AW;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_settle = LOCK;
    m_k = 0;
    for (int c = 0; c < NCH; c++) m_inc[c] = INIT[c*AW +: AW];
  endtask

  // Predicts the outputs after the coming edge, queues them, then advances one edge.
  task automatic drive_cycle();
    exp_t e;
    e = '0;
    if (cfg_valid && cfg_ready) obs_acc++;
    if (m_locked) begin
      if (cfg_valid) mdl_acc++;
      if (cfg_valid && (cfg_sel < SW'(NCH))) begin
        m_inc[cfg_sel[0]] = cfg_inc;
        m_locked = 1'b0;
        m_settle = LOCK;
        m_k = 0;
      end else begin
        m_k++;
      end
    end else begin
      m_settle--;
      if (m_settle == 0) begin
        m_locked = 1'b1;
        m_k = 0;
      end
    end
    e.lk = m_locked;
    e.rd = m_locked;
    for (int c = 0; c < NCH; c++) begin
      longint wk;
      longint wp;
      if (m_locked && m_k > 0) begin
        wk = wraps(m_inc[c], m_k);
        wp = wraps(m_inc[c], m_k - 1);
        e.ce[c] = (wk != wp);
        e.oc[c] = wp[0];
      end
    end
    sb_q.push_back(e);
    @(posedge refclk);
    #2;
  endtask

  always @(posedge refclk) begin
    #1;
    cyc++;
    if (sb_q.size() != 0) begin
      sb_e = sb_q.pop_front();
      n_checks++;
      if ({ce, outclk, locked, cfg_ready} !== sb_e) begin
        n_errors++;
        $display("FAIL sb_cycle cyc=%0d got ce=%b outclk=%b locked=%b ready=%b exp ce=%b outclk=%b locked=%b ready=%b",
                 cyc, ce, outclk, locked, cfg_ready, sb_e.ce, sb_e.oc, sb_e.lk, sb_e.rd);
      end
    end
  end

  task automatic test_reset();
    #3 rst = 1'b1;
    model_reset();
    repeat (3) @(posedge refclk);
    #7;
    n_checks++;
    if ({ce, outclk, locked, cfg_ready} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_values got=%b exp=000000", {ce, outclk, locked, cfg_ready});
    end
    rst = 1'b0;
    repeat (LOCK - 1) drive_cycle();
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL lock_early got=%b exp=0", locked);
    end
    drive_cycle();
    n_checks++;
    if (locked !== 1'b1 || cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL lock_edge got locked=%b ready=%b exp 1 1", locked, cfg_ready);
    end
  endtask

  task automatic test_default_rates();
    int n;
    int c0;
    int c1;
    int cons;
    int rises;
    int bad;
    int last;
    int exp1;
    logic p1;
    logic po;
    n = 12000; c0 = 0; c1 = 0; cons = 0; rises = 0; bad = 0; last = -1;
    p1 = ce[1]; po = outclk[0];
    repeat (n) begin
      drive_cycle();
      if (ce[0]) c0++;
      if (ce[1]) begin
        c1++;
        if (p1) cons++;
      end
      p1 = ce[1];
      if (outclk[0] && !po) begin
        if (last >= 0 && (cyc - last) != 8) bad++;
        last = cyc;
        rises++;
      end
      po = outclk[0];
    end
    exp1 = int'((longint'(n) * longint'(24'h09756A)) >> AW);
    n_checks++;
    if (c0 != 3000) begin
      n_errors++;
      $display("FAIL ch0_count got=%0d exp=3000", c0);
    end
    n_checks++;
    if (c1 < exp1 - 1 || c1 > exp1 + 1) begin
      n_errors++;
      $display("FAIL ch1_count got=%0d exp=%0d+-1", c1, exp1);
    end
    n_checks++;
    if (cons != 0) begin
      n_errors++;
      $display("FAIL ch1_consecutive got=%0d exp=0", cons);
    end
    n_checks++;
    if (bad != 0 || rises < 2) begin
      n_errors++;
      $display("FAIL outclk0_period bad_intervals=%0d rises=%0d exp 0 bad, >=2 rises", bad, rises);
    end
  endtask

  task automatic test_reprogram();
    int c0;
    cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_inc = 24'h800000;
    drive_cycle();
    cfg_valid = 1'b0;
    n_checks++;
    if ({ce, outclk, locked, cfg_ready} !== 6'b0) begin
      n_errors++;
      $display("FAIL reprog_drop got=%b exp=000000", {ce, outclk, locked, cfg_ready});
    end
    repeat (LOCK - 1) drive_cycle();
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL relock_early got=%b exp=0", locked);
    end
    drive_cycle();
    n_checks++;
    if (locked !== 1'b1) begin
      n_errors++;
      $display("FAIL relock got=%b exp=1", locked);
    end
    c0 = 0;
    repeat (100) begin
      drive_cycle();
      if (ce[0]) c0++;
    end
    n_checks++;
    if (c0 != 50) begin
      n_errors++;
      $display("FAIL ch0_half_rate got=%0d exp=50", c0);
    end
  endtask

  task automatic test_out_of_range();
    obs_acc = 0;
    cfg_valid = 1'b1; cfg_sel = 3'd5; cfg_inc = 24'h123456;
    drive_cycle();
    cfg_valid = 1'b0;
    n_checks++;
    if (obs_acc != 1 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL oor_handshake got accepts=%0d locked=%b exp 1 1", obs_acc, locked);
    end
    repeat (50) drive_cycle();
  endtask

  task automatic test_hold_valid();
    obs_acc = 0;
    mdl_acc = 0;
    cfg_valid = 1'b1; cfg_sel = 3'd1; cfg_inc = 24'h09756A;
    repeat (20) drive_cycle();
    cfg_valid = 1'b0;
    n_checks++;
    if (obs_acc != 2) begin
      n_errors++;
      $display("FAIL hold_accepts got=%0d exp=2", obs_acc);
    end
    repeat (20) drive_cycle();
    n_checks++;
    if (locked !== 1'b1) begin
      n_errors++;
      $display("FAIL hold_relock got=%b exp=1", locked);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    int c0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive_cycle();
      if (ce[0]) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL ce0_seen got=0 exp=1");
    end
    #5 rst = 1'b1;
    #1;
    n_checks++;
    if ({ce, outclk, locked, cfg_ready} !== 6'b0) begin
      n_errors++;
      $display("FAIL async_rst_locked got=%b exp=000000", {ce, outclk, locked, cfg_ready});
    end
    @(posedge refclk);
    #6 rst = 1'b0;
    model_reset();
    repeat (LOCK) drive_cycle();
    cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_inc = 24'h000000;
    drive_cycle();
    cfg_valid = 1'b0;
    repeat (5) drive_cycle();
    #5 rst = 1'b1;
    #1;
    n_checks++;
    if ({ce, outclk, locked, cfg_ready} !== 6'b0) begin
      n_errors++;
      $display("FAIL async_rst_settle got=%b exp=000000", {ce, outclk, locked, cfg_ready});
    end
    @(posedge refclk);
    #6 rst = 1'b0;
    model_reset();
    repeat (LOCK) drive_cycle();
    c0 = 0;
    repeat (40) begin
      drive_cycle();
      if (ce[0]) c0++;
    end
    n_checks++;
    if (c0 != 10) begin
      n_errors++;
      $display("FAIL init_restored got=%0d exp=10", c0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_default_rates();
    test_reprogram();
    test_out_of_range();
    test_hold_valid();
    test_async_reset();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
